rr_arb_mux: RTL and testbench

- Parametrised N-channel, W-bit arbitrating multiplexer with valid/ready handshake on every input and a registered output stage.
- Next generation of the datapath word mux: the select is generated internally by a round-robin or fixed-priority arbiter rather than driven by control.
- Merges multiple producers onto one consumer, e.g. memory-request merging or write-back port sharing in the pipelined datapath.

---
 rtl/rr_arb_mux_pkg.sv | 10 +
 rtl/rr_arb_mux_rr_arbiter.sv | 25 ++
 rtl/rr_arb_mux.sv | 84 ++++++++
 tb/tb_rr_arb_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared constants and helpers for the arbitrating word mux.
package rr_arb_mux_pkg;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arb_mux_rr_arbiter.sv
// rr_arbiter: combinational rotating or fixed-priority arbiter, one-hot and binary grant.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SW = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SW-1:0]     i_ptr,
    input  logic              i_mode,
    output logic [NUM_CH-1:0] o_grant,
    output logic [SW-1:0]     o_idx
);
    logic [SW-1:0] w_c;
    always_comb begin
        o_idx = '0;
        w_c = '0;
        // scan farthest-first so the requester nearest the pointer is written last and wins
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_c = i_mode ? SW'(k) : SW'((int'(i_ptr) + k) % NUM_CH);
            if (i_req[w_c]) o_idx = w_c;
        end
        o_grant = (|i_req) ? (NUM_CH'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating word mux, valid/ready inputs, registered output.
// Define RR_ARB_MUX_LOCK_EN to keep the grant on one channel until its in_last beat.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 4,
    parameter int PRIO_MODE = PRIO_RR,
    localparam int SW = clog2_min1(NUM_CH)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
`endif
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SW-1:0]           out_sel
);
    logic [NUM_CH-1:0] w_req, w_grant;
    logic [SW-1:0]     w_idx, r_ptr, r_sel;
    logic [WIDTH-1:0]  r_data;
    logic              r_valid, w_load, w_fire, w_last;

    assign w_load   = !r_valid || out_ready;
    assign w_fire   = w_load && |w_req;
    assign in_ready = w_grant & {NUM_CH{w_load}};
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

`ifdef RR_ARB_MUX_LOCK_EN
    logic [0:0]    r_state;
    logic [SW-1:0] r_lock_ch;
    // while locked only the owning channel may request, even if it is momentarily idle
    assign w_req  = (r_state == LOCKED) ? (in_valid & (NUM_CH'(1) << r_lock_ch)) : in_valid;
    assign w_last = in_last[w_idx];
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= IDLE;
            r_lock_ch <= '0;
        end else if (w_fire) begin
            if (r_state == IDLE && !w_last) begin
                r_state   <= LOCKED;
                r_lock_ch <= w_idx;
            end else if (r_state == LOCKED && w_last) begin
                r_state <= IDLE;
            end
        end
    end
`else
    assign w_req  = in_valid;
    assign w_last = 1'b1;
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_mode  (PRIO_MODE == PRIO_FIXED),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= |w_req;
            if (|w_req) begin
                r_data <= in_data[w_idx*WIDTH +: WIDTH];
                r_sel  <= w_idx;
            end
            if (w_fire && w_last && PRIO_MODE == PRIO_RR)
                r_ptr <= (w_idx == SW'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: scoreboard bench for rr_arb_mux (round-robin and fixed-priority instances).
module tb_rr_arb_mux;
    localparam int W = 32, NC = 4, SW = 2;
    logic Clk = 1'b0, Rst = 1'b0;
    logic [NC*W-1:0] in_data = '0;
    logic [NC-1:0] in_valid = '0, in_ready, fp_in_ready;
    logic out_ready = 1'b1;
    logic [W-1:0] out_data, fp_out_data;
    logic out_valid, fp_out_valid;
    logic [SW-1:0] out_sel, fp_out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [NC-1:0] in_last = '1;
    logic m_locked = 1'b0;
    int m_lch = 0;
`endif
    int n_chk = 0, n_fail = 0, seq = 0, m_ptr = 0;
    logic m_valid = 1'b0;
    logic [SW+W-1:0] q[$];

    always #5 Clk = ~Clk;

    rr_arb_mux #(.WIDTH(W), .NUM_CH(NC), .PRIO_MODE(0)) dut (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sel(out_sel)
    );

    rr_arb_mux #(.WIDTH(W), .NUM_CH(NC), .PRIO_MODE(1)) dut_fp (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_valid(fp_out_valid),
        .out_ready(out_ready), .out_sel(fp_out_sel)
    );

    task automatic set_data();
        for (int c = 0; c < NC; c++) in_data[c*W +: W] = {4'hD, 4'(c), 24'(seq)};
        seq++;
    endtask

    // one clock of the round-robin reference model; entered and left at posedge+1
    task automatic step();
        int g;
        logic ld, lst;
        logic [SW-1:0] c, gi;
        logic [NC-1:0] req, exp_rdy;
        #1;
        ld = !m_valid || out_ready;
        req = in_valid;
        lst = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        if (m_locked) req = in_valid & (NC'(1) << m_lch);
`endif
        g = -1;
        for (int k = 0; k < NC; k++) begin
            c = SW'((m_ptr + k) % NC);
            if (g < 0 && req[c]) g = int'(c);
        end
        gi = SW'(g < 0 ? 0 : g);
        exp_rdy = (ld && g >= 0) ? (NC'(1) << gi) : '0;
        n_chk++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        if (m_valid) begin
            n_chk++;
            if (q.size() == 0 || {out_sel, out_data} !== q[0]) begin
                n_fail++;
                $display("FAIL out_word: got sel=%0d data=%h expected %h", out_sel, out_data,
                         q.size() ? q[0] : '0);
            end
            if (out_ready && q.size() > 0) void'(q.pop_front());
        end
        if (ld) begin
            if (g >= 0) begin
                q.push_back({gi, in_data[gi*W +: W]});
                m_valid = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
                lst = in_last[gi];
                if (!m_locked && !lst) begin
                    m_locked = 1'b1;
                    m_lch = g;
                end else if (m_locked && lst) m_locked = 1'b0;
`endif
                if (lst) m_ptr = (g + 1) % NC;
            end else m_valid = 1'b0;
        end
        @(posedge Clk);
        #1;
        n_chk++;
        if (out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got v=%b d=%h s=%0d r=%b expected all zero",
                     out_valid, out_data, out_sel, in_ready);
        end
        @(negedge Clk) Rst = 1'b1;
        @(posedge Clk) #1;
        in_valid = '1;
        for (int i = 0; i < 2; i++) begin
            set_data();
            step();
        end
        Rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b d=%h s=%0d expected 0 0 0", out_valid, out_data, out_sel);
        end
        m_valid = 1'b0;
        m_ptr = 0;
        q.delete();
        in_valid = '0;
        @(negedge Clk) Rst = 1'b1;
        @(posedge Clk) #1;
    endtask

    task automatic test_rr_fairness();
        logic [SW-1:0] exp_sel;
        in_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_data();
            step();
            exp_sel = SW'(i % NC);
            n_chk++;
            if (out_sel !== exp_sel) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, out_sel, exp_sel);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        in_valid = '1;
        set_data();
        step();
        held = out_sel;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        step();
        n_chk++;
        if (out_sel !== held + 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: got sel=%0d v=%b expected sel=%0d v=1", out_sel, out_valid, held + 1'b1);
        end
    endtask

    task automatic test_fixed_prio();
        in_valid = 4'b1010;
        in_data[1*W +: W] = 32'hAAAA0001;
        in_data[3*W +: W] = 32'hCCCC0003;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (fp_in_ready !== 4'b0010) begin
                n_fail++;
                $display("FAIL fp_ready[%0d]: got %b expected 0010", i, fp_in_ready);
            end
            step();
            n_chk++;
            if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 32'hAAAA0001) begin
                n_fail++;
                $display("FAIL fp_out[%0d]: got v=%b s=%0d d=%h expected 1 1 aaaa0001",
                         i, fp_out_valid, fp_out_sel, fp_out_data);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [NC-1:0] pat[4] = '{4'b1000, 4'b0001, 4'b1111, 4'b0000};
        logic [SW-1:0] exp_sel[3] = '{2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i];
            set_data();
            step();
            n_chk++;
            if (i < 3 && out_sel !== exp_sel[i]) begin
                n_fail++;
                $display("FAIL wrap_sel[%0d]: got %0d expected %0d", i, out_sel, exp_sel[i]);
            end else if (i == 3 && out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_drop: got out_valid=%b expected 0", out_valid);
            end
        end
    endtask

`ifdef RR_ARB_MUX_LOCK_EN
    task automatic test_lock();
        logic [SW-1:0] exp_sel[4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        in_last = '1;
        in_valid = 4'b0010;
        set_data();
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 3) ? 4'b0101 : 4'b0001;
            in_last = (i == 2) ? 4'b1111 : 4'b1011;
            set_data();
            #1;
            n_chk++;
            if (i < 3 && in_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_ch0_ready[%0d]: got %b expected 0", i, in_ready[0]);
            end
            step();
            n_chk++;
            if (out_sel !== exp_sel[i]) begin
                n_fail++;
                $display("FAIL lock_sel[%0d]: got %0d expected %0d", i, out_sel, exp_sel[i]);
            end
        end
        in_last = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_fixed_prio();
        test_sparse_wrap();
`ifdef RR_ARB_MUX_LOCK_EN
        test_lock();
`endif
        in_valid = '0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
